pixel_readout_ctrl: RTL and testbench

- Parametrised frame sequencer and readout engine for a NUM_ROWS x NUM_COLS pixel array.
- Drives erase, expose and convert phases and generates the shared ADC ramp code.
- Selects rows one at a time, captures each row bus, and serialises pixels onto one valid/ready stream with frame markers.
- Sits between the pixel array and the downstream readout/FIFO logic; generalises the fixed 2x2, 4-bus pixel top.

---
 rtl/pixel_readout_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pixel_readout_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer and row-by-row pixel readout engine for a NUM_ROWS x NUM_COLS array.
// Define PIXEL_TEST_PATTERN_EN to replace captured row data with a (r*NUM_COLS+c) pattern.
module pixel_readout_ctrl #(
  parameter int NUM_ROWS     = 2,
  parameter int NUM_COLS     = 2,
  parameter int PIX_W        = 8,
  parameter int EXP_W        = 8,
  parameter int ERASE_CYCLES = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [EXP_W-1:0]          expose_cycles,
  output logic                      erase,
  output logic                      expose,
  output logic                      convert,
  output logic [PIX_W-1:0]          adc_code,
  output logic [NUM_ROWS-1:0]       row_sel,
  input  logic [NUM_COLS*PIX_W-1:0] row_data,
  output logic [PIX_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_first,
  output logic                      out_last,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int M1 = (ERASE_CYCLES > (1 << EXP_W)) ? ERASE_CYCLES : (1 << EXP_W);
  localparam int PH_MAX = (M1 > (1 << PIX_W)) ? M1 : (1 << PIX_W);
  localparam int CNT_W = $clog2(PH_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_ROW_LATCH,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [EXP_W-1:0]          exp_q;
  logic [RW-1:0]             row_q;
  logic [CW-1:0]             col_q;
  logic [NUM_COLS*PIX_W-1:0] buf_q;
  logic [NUM_COLS*PIX_W-1:0] buf_d;
  logic                      erase_q;
  logic                      expose_q;
  logic                      convert_q;
  logic [PIX_W-1:0]          adc_q;
  logic [NUM_ROWS-1:0]       row_sel_q;
  logic                      valid_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      last_col;
  logic                      last_row;

`ifdef PIXEL_TEST_PATTERN_EN
  always_comb begin
    buf_d = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      buf_d[c*PIX_W +: PIX_W] = PIX_W'(int'(row_q) * NUM_COLS + c);
    end
  end
`else
  assign buf_d = row_data;
`endif

  assign last_col = (col_q == CW'(NUM_COLS - 1));
  assign last_row = (row_q == RW'(NUM_ROWS - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      exp_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      buf_q     <= '0;
      erase_q   <= 1'b0;
      expose_q  <= 1'b0;
      convert_q <= 1'b0;
      adc_q     <= '0;
      row_sel_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            exp_q   <= (expose_cycles == '0) ? EXP_W'(1)
                                             : expose_cycles;
            cnt_q   <= CNT_W'(ERASE_CYCLES - 1);
            erase_q <= 1'b1;
            busy_q  <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            state_q <= S_ERASE;
          end
        end
        S_ERASE: begin
          if (cnt_q == '0) begin
            erase_q  <= 1'b0;
            expose_q <= 1'b1;
            cnt_q    <= CNT_W'(exp_q) - CNT_W'(1);
            state_q  <= S_EXPOSE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_EXPOSE: begin
          if (cnt_q == '0) begin
            expose_q  <= 1'b0;
            convert_q <= 1'b1;
            adc_q     <= '0;
            state_q   <= S_CONVERT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_CONVERT: begin
          if (adc_q == '1) begin
            convert_q <= 1'b0;
            adc_q     <= '0;
            row_sel_q <= NUM_ROWS'(1);
            state_q   <= S_ROW_LATCH;
          end else begin
            adc_q <= adc_q + PIX_W'(1);
          end
        end
        S_ROW_LATCH: begin
          buf_q     <= buf_d;
          row_sel_q <= '0;
          col_q     <= '0;
          valid_q   <= 1'b1;
          state_q   <= S_STREAM;
        end
        S_STREAM: begin
          if (out_ready) begin
            if (!last_col) begin
              col_q <= col_q + CW'(1);
            end else begin
              valid_q <= 1'b0;
              col_q   <= '0;
              if (last_row) begin
                row_q   <= '0;
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end else begin
                row_q     <= row_q + RW'(1);
                row_sel_q <= NUM_ROWS'(1) << (row_q + RW'(1));
                state_q   <= S_ROW_LATCH;
              end
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Flags and data decode from registered state, so they hold while stalled.
  assign out_valid  = valid_q;
  assign out_data   = valid_q ? buf_q[int'(col_q)*PIX_W +: PIX_W] : '0;
  assign out_first  = valid_q && (row_q == '0) && (col_q == '0);
  assign out_last   = valid_q && last_row && last_col;
  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign adc_code   = adc_q;
  assign row_sel    = row_sel_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl with default 2x2, 8-bit parameters.
// Expected pixels follow the test pattern when PIXEL_TEST_PATTERN_EN is defined.
module tb_pixel_readout_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  expose_cycles;
  logic        erase;
  logic        expose;
  logic        convert;
  logic [7:0]  adc_code;
  logic [1:0]  row_sel;
  logic [15:0] row_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_first;
  logic        out_last;
  logic        busy;
  logic        frame_done;

  logic [15:0] rd0 = 16'hB2A1;
  logic [15:0] rd1 = 16'hD4C3;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign row_data = row_sel[0] ? rd0 : (row_sel[1] ? rd1 : 16'h0000);

  pixel_readout_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .expose_cycles (expose_cycles),
    .erase         (erase),
    .expose        (expose),
    .convert       (convert),
    .adc_code      (adc_code),
    .row_sel       (row_sel),
    .row_data      (row_data),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_first     (out_first),
    .out_last      (out_last),
    .busy          (busy),
    .frame_done    (frame_done)
  );

  task automatic check(input string name, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    vec++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] exp_pix(input int i);
`ifdef PIXEL_TEST_PATTERN_EN
    return 8'(i);
`else
    logic [7:0] t [4];
    t[0] = 8'hA1; t[1] = 8'hB2; t[2] = 8'hC3; t[3] = 8'hD4;
    return t[i];
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_strobes"},
          {erase, expose, convert, out_valid, out_first, out_last, busy, frame_done}, 0);
    check({tag, "_adc"}, adc_code, 0);
    check({tag, "_rowsel"}, row_sel, 0);
    check({tag, "_data"}, out_data, 0);
  endtask

  // mode 0: ready high, 1: backpressure, 2: start pokes, 3: reset mid-stream
  task automatic frame(input int e, input int mode, input string tag);
    int busy_n = 0, er_n = 0, ex_n = 0, cv_n = 0, adc_bad = 0;
    int rs_bad = 0, stall_bad = 0, fd_n = 0, fd_cyc = -1, last_cyc = -2;
    int stall_left = 4, cyc = 0, e_eff, fm = 0, lm = 0;
    logic [7:0] pdata = 0;
    logic pf = 0, pl = 0, pstall = 0;
    logic [1:0] rs_q [$];
    logic [7:0] bd [$];
    logic bf [$];
    logic bl [$];
    e_eff = (e == 0) ? 1 : e;
    out_ready = 1'b1;
    expose_cycles = 8'(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_erase_rise"}, erase, 1);
    while (cyc < 5000) begin
      if (!busy) break;
      busy_n++;
      er_n += int'(erase);
      ex_n += int'(expose);
      if (convert) begin
        if (adc_code != 8'(cv_n)) adc_bad++;
        cv_n++;
      end else if (adc_code != 0) adc_bad++;
      if (row_sel != 0) begin
        rs_q.push_back(row_sel);
        if (out_valid) rs_bad++;
      end
      if (frame_done) begin
        fd_n++;
        fd_cyc = cyc;
      end
      if (pstall && (!out_valid || out_data != pdata ||
                     out_first != pf || out_last != pl)) stall_bad++;
      if (mode == 1 && bd.size() >= 1) begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else out_ready = 1'($urandom_range(0, 1));
      end else out_ready = 1'b1;
      if (mode == 2)
        start = (convert && cv_n == 11) || (out_valid && bd.size() == 0);
      if (mode == 3 && bd.size() == 2 && out_valid) begin
        reset = 1'b0;
        return;
      end
      if (out_valid && out_ready) begin
        bd.push_back(out_data);
        bf.push_back(out_first);
        bl.push_back(out_last);
        last_cyc = cyc;
      end
      pstall = out_valid && !out_ready;
      pdata = out_data;
      pf = out_first;
      pl = out_last;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check({tag, "_timeout"}, (cyc < 5000), 1);
    check({tag, "_erase_n"}, er_n, 5);
    check({tag, "_expose_n"}, ex_n, e_eff);
    check({tag, "_convert_n"}, cv_n, 256);
    check({tag, "_adc_seq"}, adc_bad, 0);
    check({tag, "_rowsel_n"}, rs_q.size(), 2);
    if (rs_q.size() == 2) begin
      check({tag, "_rowsel0"}, rs_q[0], 2'b01);
      check({tag, "_rowsel1"}, rs_q[1], 2'b10);
    end
    check({tag, "_rowsel_valid"}, rs_bad, 0);
    check({tag, "_beats"}, bd.size(), 4);
    for (int i = 0; i < bd.size() && i < 4; i++) begin
      check($sformatf("%s_pix%0d", tag, i), bd[i], exp_pix(i));
      fm |= int'(bf[i]) << i;
      lm |= int'(bl[i]) << i;
    end
    check({tag, "_first_mask"}, fm, 4'b0001);
    check({tag, "_last_mask"}, lm, 4'b1000);
    check({tag, "_done_n"}, fd_n, 1);
    check({tag, "_done_pos"}, fd_cyc, last_cyc + 1);
    check({tag, "_stall_hold"}, stall_bad, 0);
    if (mode != 1)
      check({tag, "_frame_len"}, busy_n + 1, 1 + 5 + e_eff + 256 + 6 + 1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    expose_cycles = 8'd0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle("idle");

    frame(3, 0, "f1");
    frame(0, 0, "e0");
    frame(255, 0, "e255");
    frame(3, 1, "bp");
    frame(3, 2, "poke");
    frame(3, 0, "b2b");

    frame(3, 3, "abort");
    check("abort_reached", reset, 0);
    @(negedge clk);
    reset = 1'b1;
    check_idle("abort_clr");
    frame(3, 0, "after");

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
